// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types, widths and the code-to-line helper for decoder_2_to_4_sequenced
package decoder_pkg;
  typedef enum logic {IDLE, DRIVE} state_t;
  localparam int CODE_W = 2;
  localparam int LINES_W = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int HOLD_W = 4;
  function automatic logic [LINES_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return LINES_W'(1) << code;
  endfunction
endpackage

// File: rtl/decoder_2_to_4_sequenced_code_fifo_2.sv
// code_fifo_2: 2-entry synchronous FIFO of codes with first-word-out head
module code_fifo_2
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [CODE_W-1:0] i_data,
  output logic [CODE_W-1:0] o_head,
  output logic [1:0]        o_count
);
  logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]        r_count;
  logic [1:0]        w_idx;
  logic              w_push;
  logic              w_pop;
  assign w_push = i_push && r_count != 2'd2;
  assign w_pop = i_pop && r_count != 2'd0;
  // a same-edge pop shifts the queue down, so the push lands one slot lower
  assign w_idx = r_count - {1'b0, w_pop};
  assign o_head = r_mem[0];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) r_mem[0] <= r_mem[1];
      if (w_push) r_mem[w_idx[0]] <= i_data;
    end
  end
endmodule

// File: rtl/decoder_2_to_4_sequenced.sv
// decoder_2_to_4_sequenced: buffered 2-to-4 decoder driving timed one-hot strobes.
// Define DECODER_2_TO_4_ACTIVE_LOW_EN for one-cold out_lines (idle 1111).
module decoder_2_to_4_sequenced
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CODE_W-1:0]  in_lines,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LINES_W-1:0] out_lines,
  output logic               out_active
);
`ifdef DECODER_2_TO_4_ACTIVE_LOW_EN
  localparam logic [LINES_W-1:0] LINE_XOR = '1;
`else
  localparam logic [LINES_W-1:0] LINE_XOR = '0;
`endif
  state_t              r_state, w_next;
  logic [HOLD_W-1:0]   r_cnt;
  logic [LINES_W-1:0]  r_lines;
  logic [CODE_W-1:0]   w_head, w_code;
  logic [1:0]          w_count;
  logic                w_slot, w_xfer, w_pop, w_bypass, w_push, w_load;
  code_fifo_2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_lines),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign in_ready = w_count != 2'd2;
  assign out_lines = r_lines;
  assign out_active = r_state == DRIVE;
  // w_slot marks an edge where a new strobe may start: idle, or the last hold cycle
  always_comb begin
    w_slot = r_state == IDLE || r_cnt == '0;
    w_xfer = in_valid && in_ready;
    w_pop = w_slot && w_count != 2'd0;
    w_bypass = w_slot && w_count == 2'd0 && w_xfer;
    w_push = w_xfer && !w_bypass;
    w_load = w_pop || w_bypass;
    w_code = w_pop ? w_head : in_lines;
    w_next = w_load ? DRIVE : (w_slot ? IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_lines <= LINE_XOR;
    end else if (w_load) begin
      r_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      r_lines <= code_to_onehot(w_code) ^ LINE_XOR;
    end else if (w_slot) begin
      r_cnt <= '0;
      r_lines <= LINE_XOR;
    end else begin
      r_cnt <= r_cnt - HOLD_W'(1);
    end
  end
endmodule

// File: tb/tb_decoder_2_to_4_sequenced.sv
// tb_decoder_2_to_4_sequenced: directed checks of HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
module tb_decoder_2_to_4_sequenced;
`ifdef DECODER_2_TO_4_ACTIVE_LOW_EN
  localparam logic [3:0] X = 4'hF;
`else
  localparam logic [3:0] X = 4'h0;
`endif
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_lines, in_lines1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic [3:0] out_lines, out_lines1;
  logic       out_active, out_active1;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp1 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  decoder_2_to_4_sequenced #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_lines(in_lines), .in_valid(in_valid),
    .in_ready(in_ready), .out_lines(out_lines), .out_active(out_active)
  );
  decoder_2_to_4_sequenced #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_lines(in_lines1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_lines(out_lines1), .out_active(out_active1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_lines = 2'd0; in_valid1 = 1'b0; in_lines1 = 2'd0;
    tick(); tick();
    chk("rst_lines", 8'(out_lines), 8'(X));
    chk("rst_active", 8'(out_active), 8'd0);
    chk("rst_ready", 8'(in_ready), 8'd1);
    rst = 1'b0;
    tick();
    in_lines = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single_lines", 8'(out_lines), 8'(4'b0100 ^ X));
      chk("single_active", 8'(out_active), 8'd1);
      tick();
    end
    chk("single_end_lines", 8'(out_lines), 8'(X));
    chk("single_end_active", 8'(out_active), 8'd0);
    in_valid = 1'b1; in_lines = 2'd3;
    tick();
    chk("burst_s0", 8'(out_lines), 8'(4'b1000 ^ X));
    in_lines = 2'd0;
    tick();
    chk("burst_s1", 8'(out_lines), 8'(4'b1000 ^ X));
    in_lines = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("burst_s2", 8'(out_lines), 8'(4'b1000 ^ X));
    chk("burst_full", 8'(in_ready), 8'd0);
    tick();
    chk("burst_s3", 8'(out_lines), 8'(4'b1000 ^ X));
    chk("burst_full2", 8'(in_ready), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_code0", 8'(out_lines), 8'(4'b0001 ^ X));
      if (i == 0) chk("burst_ready_rise", 8'(in_ready), 8'd1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_code1", 8'(out_lines), 8'(4'b0010 ^ X));
      chk("burst_active", 8'(out_active), 8'd1);
    end
    tick();
    chk("burst_idle", 8'(out_lines), 8'(X));
    chk("burst_idle_active", 8'(out_active), 8'd0);
    in_valid1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_lines1 = 2'(c);
      tick();
      chk("h1_lines", 8'(out_lines1), 8'(exp1[c] ^ X));
      chk("h1_ready", 8'(in_ready1), 8'd1);
    end
    in_valid1 = 1'b0;
    tick();
    chk("h1_idle", 8'(out_lines1), 8'(X));
    chk("h1_idle_active", 8'(out_active1), 8'd0);
    in_valid = 1'b1; in_lines = 2'd1;
    tick();
    in_lines = 2'd2;
    tick();
    in_lines = 2'd3;
    tick();
    chk("pre_rst_lines", 8'(out_lines), 8'(4'b0010 ^ X));
    chk("pre_rst_full", 8'(in_ready), 8'd0);
    rst = 1'b1; in_lines = 2'd0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_lines", 8'(out_lines), 8'(X));
    chk("mid_rst_ready", 8'(in_ready), 8'd1);
    chk("mid_rst_active", 8'(out_active), 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_lines", 8'(out_lines), 8'(X));
      chk("post_rst_active", 8'(out_active), 8'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
